// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory and presents one
// fetched instruction at a time in the IF/ID register, halting on an illegal PC.
module instr_fetch_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
   parameter int                    ROM_WORDS  = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_rd,
   input  logic                  stall,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   input  logic                  id_ready,
   output logic                  if_valid,
   output logic [DATA_WIDTH-1:0] if_instr,
   output logic [DATA_WIDTH-1:0] if_pc,
   output logic [DATA_WIDTH-1:0] if_pc_plus4,
   output logic                  fetch_fault,
   output logic [31:0]           fetch_count,
   output logic [1:0]            o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   // Wide enough that RESET_PC + 4*ROM_WORDS never truncates.
   localparam int            XW      = DATA_WIDTH + 34;
   localparam logic [XW-1:0] BASE_X  = XW'(RESET_PC);
   localparam logic [XW-1:0] LIMIT_X = BASE_X + (XW'(ROM_WORDS) << 2);

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] r_instr;
   logic [DATA_WIDTH-1:0] r_if_pc;
   logic [DATA_WIDTH-1:0] r_if_pc4;
   logic                  r_valid;
   logic                  r_fault;
   logic [31:0]           r_count;

   logic w_legal;
   logic w_advance;
   logic w_handover;

   // Handshake: an IF/ID entry is handed to decode on every edge where
   // if_valid && id_ready and no redirect flushes it; each entry goes over once.
   assign w_legal    = (r_pc[1:0] == 2'b00) && (XW'(r_pc) >= BASE_X) && (XW'(r_pc) < LIMIT_X);
   assign w_advance  = !stall && (!r_valid || id_ready);
   assign w_handover = r_valid && id_ready && !redirect_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_pc     <= RESET_PC;
         r_instr  <= '0;
         r_if_pc  <= '0;
         r_if_pc4 <= '0;
         r_valid  <= 1'b0;
         r_fault  <= 1'b0;
         r_count  <= '0;
      end else begin
         if (w_handover) begin
            r_count <= r_count + 32'd1;
         end
         case (r_state)
            S_IDLE: begin
               r_state <= S_FETCH;
            end
            S_FETCH: begin
               if (redirect_valid) begin
                  r_pc    <= redirect_pc;
                  r_valid <= 1'b0;
               end else if (!w_legal) begin
                  r_state <= S_HALT;
                  r_fault <= 1'b1;
                  r_valid <= 1'b0;
               end else if (w_advance) begin
                  r_instr  <= imem_rd;
                  r_if_pc  <= r_pc;
                  r_if_pc4 <= r_pc + DATA_WIDTH'(4);
                  r_pc     <= r_pc + DATA_WIDTH'(4);
                  r_valid  <= 1'b1;
               end else if (r_valid && id_ready) begin
                  // Only reachable under stall: the entry was consumed, so drop
                  // valid while keeping the frozen payload.
                  r_valid <= 1'b0;
               end
            end
            S_HALT: begin
               if (redirect_valid) begin
                  r_state <= S_FETCH;
                  r_fault <= 1'b0;
                  r_pc    <= redirect_pc;
                  r_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_fault <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign imem_addr   = r_pc;
   assign if_valid    = r_valid;
   assign if_instr    = r_instr;
   assign if_pc       = r_if_pc;
   assign if_pc_plus4 = r_if_pc4;
   assign fetch_fault = r_fault;
   assign fetch_count = r_count;
   assign o_dbg_state = r_state;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of instruction and PC data.
REQ-002 Parameter RESET_PC, default 32'h0040_0000, SHALL set the program base address and the PC value after reset.
REQ-003 Parameter ROM_WORDS, default 1024, SHALL set the number of legal instruction words starting at RESET_PC.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-006 imem_addr  output  DATA_WIDTH  SHALL be the current PC, driven combinationally from pc_q, to the instruction memory address input.
REQ-007 imem_rd  input  DATA_WIDTH  SHALL be the instruction word returned combinationally by the instruction memory for imem_addr.
REQ-008 stall  input  1  SHALL be the hazard-unit stall; high freezes PC and IF/ID.
REQ-009 redirect_valid  input  1  SHALL be the branch/jump taken strobe.
REQ-010 redirect_pc  input  DATA_WIDTH  SHALL be the target PC, sampled when redirect_valid=1.
REQ-011 id_ready  input  1  SHALL indicate that decode accepts the IF/ID contents this cycle.
REQ-012 if_valid  output  1  SHALL indicate that if_instr, if_pc and if_pc_plus4 hold a valid fetched instruction.
REQ-013 if_instr, if_pc, if_pc_plus4  output  DATA_WIDTH each  SHALL be the registered instruction, its address, and address+4.
REQ-014 fetch_fault  output  1  SHALL be high while the unit is in HALT.
REQ-015 fetch_count  output  32  SHALL count instructions handed to decode.

Function
REQ-016 The state machine SHALL have the states IDLE, FETCH and HALT; reset enters IDLE; IDLE unconditionally goes to FETCH on the next cycle without fetching.
REQ-017 A PC SHALL be legal when pc[1:0]==0 and RESET_PC <= pc < RESET_PC+4*ROM_WORDS, with the comparison done unsigned and without truncation.
REQ-018 In FETCH, advance SHALL be defined as !stall && (!if_valid || id_ready).
REQ-019 On advance with a legal pc_q, the unit SHALL, in one edge, load if_instr<=imem_rd, if_pc<=pc_q, if_pc_plus4<=pc_q+4, set if_valid<=1 and set pc_q<=pc_q+4; fetch latency is 1 cycle.
REQ-020 PC addition SHALL wrap modulo 2^DATA_WIDTH; the resulting illegal PC SHALL be handled as a fault under REQ-023.
REQ-021 When if_valid && id_ready && !advance, if_valid SHALL clear, so that each instruction is handed over exactly once.
REQ-022 When stall=1 with no redirect, pc_q and all IF/ID outputs SHALL hold their values.
REQ-023 In FETCH, an illegal pc_q SHALL move the state to HALT on the next edge, clear if_valid and leave pc_q unchanged; no fetch SHALL occur from that PC.
REQ-024 Priority per edge SHALL be reset > redirect > fault > stall > advance.
REQ-025 When redirect_valid=1 in FETCH or HALT, the unit SHALL load pc_q<=redirect_pc, clear if_valid (flush, including a coincident fetch) and enter FETCH regardless of stall.
REQ-026 An illegal redirect_pc SHALL enter FETCH and then fault under REQ-023.
REQ-027 In HALT, the unit SHALL hold pc_q, keep if_valid=0 and keep fetch_fault=1 until a redirect or a reset.
REQ-028 fetch_count SHALL increment by 1 on every edge where if_valid && id_ready && !redirect_valid, and SHALL wrap from 0xFFFF_FFFF to 0.
REQ-029 In IDLE, redirect_valid SHALL be ignored.

Reset
REQ-030 When rst_n=0 at an edge, the unit SHALL set state=IDLE, pc_q=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, fetch_fault=0 and fetch_count=0, overriding all other inputs.
REQ-031 Reset asserted mid-operation, including in HALT or during a stall, SHALL abandon any in-flight IF/ID contents with no partial update.

Verification
REQ-032 Reset then run, with memory word k = 0x1000_0000+k, id_ready=1 and stall=0 -> cycle 2 has if_pc=0x0040_0000, if_instr=0x1000_0000; then one instruction per cycle; fetch_count=3 after three handovers.
REQ-033 stall=1 for 3 cycles while if_pc=0x0040_0008 -> outputs frozen, imem_addr=0x0040_000C throughout; the fetch resumes with 0x0040_000C after stall drops.
REQ-034 redirect_valid=1, redirect_pc=0x0040_0100, with stall=1 the same cycle -> next cycle if_valid=0, imem_addr=0x0040_0100; the following cycle if_pc=0x0040_0100.
REQ-035 id_ready=0 for 2 cycles -> if_pc held, pc_q not incremented, fetch_count unchanged; no instruction duplicated or dropped.
REQ-036 Sequential run to the last word 0x0040_0FFC -> the fetch of 0x0040_0FFC succeeds; pc_q=0x0040_1000 then enters HALT with fetch_fault=1 and if_valid=0; redirect to 0x0040_0000 recovers.
REQ-037 redirect_pc=0x0040_0002 (misaligned) and separately 0x0000_0000 -> HALT within 2 cycles, no if_valid pulse; rst_n=0 for one edge in HALT -> all outputs return to the reset values of REQ-030.
